// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator controller slice.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DOOR   = 2'd1,
        MOVE   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_MOVE_CYCLES = 4;
    localparam int DEFAULT_DOOR_CYCLES = 8;

    // Wide enough to hold the larger of the two reload values.
    function automatic int timer_width(input int move_cycles, input int door_cycles);
        return $clog2(((move_cycles > door_cycles) ? move_cycles : door_cycles) + 1);
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down counter shared by the door dwell and floor travel phases.
module elevator_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic [TW-1:0] count,
    output logic          zero
);

    logic [TW-1:0] count_d;
    logic [TW-1:0] count_q;

    // Load wins over decrement; the counter saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/elevator_controller.sv
// SCAN elevator sequencer: decides door/travel phases and pulses the datapath one floor at a time.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int MOVE_CYCLES = DEFAULT_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEFAULT_DOOR_CYCLES,
    localparam int TW = timer_width(MOVE_CYCLES, DOOR_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic request_i,
    input  logic request_j_gt_i,
    input  logic request_j_lt_i,
    input  logic door_hold,
    output logic up,
    output logic down,
    output logic open,
    output logic dir_up,
    output logic busy
);

    localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

    state_t        state_d, state_q;
    logic          dir_d, dir_q;
    logic          up_d, up_q;
    logic          down_d, down_q;
    logic          open_d, open_q;
    logic          busy_d, busy_q;

    logic          t_load;
    logic [TW-1:0] t_load_val;
    logic          t_dec;
    logic [TW-1:0] t_count;
    logic          t_zero;
    logic          ahead;
    logic          behind;
    logic          step;

    elevator_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_load_val),
        .dec      (t_dec),
        .count    (t_count),
        .zero     (t_zero)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        t_load     = 1'b0;
        t_load_val = MOVE_LOAD;
        t_dec      = 1'b0;
        ahead      = dir_q ? request_j_gt_i : request_j_lt_i;
        behind     = dir_q ? request_j_lt_i : request_j_gt_i;

        case (state_q)
            IDLE: begin
                if (request_i) begin
                    state_d    = DOOR;
                    t_load     = 1'b1;
                    t_load_val = DOOR_LOAD;
                end else if (request_j_gt_i) begin
                    state_d = MOVE;
                    dir_d   = DIR_UP;
                    t_load  = 1'b1;
                end else if (request_j_lt_i) begin
                    state_d = MOVE;
                    dir_d   = DIR_DOWN;
                    t_load  = 1'b1;
                end
            end
            DOOR: begin
                if (t_zero && !door_hold) begin
                    state_d = SETTLE;
                end else if (door_hold) begin
                    t_load     = 1'b1;
                    t_load_val = DOOR_LOAD;
                end else begin
                    t_dec = 1'b1;
                end
            end
            MOVE: begin
                if (t_zero) begin
                    state_d = SETTLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (request_i) begin
                    state_d    = DOOR;
                    t_load     = 1'b1;
                    t_load_val = DOOR_LOAD;
                end else if (ahead) begin
                    state_d = MOVE;
                    t_load  = 1'b1;
                end else if (behind) begin
                    state_d = MOVE;
                    dir_d   = ~dir_q;
                    t_load  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The pulse lands in the last MOVE cycle so the floor changes before SETTLE samples the flags.
        step   = (state_d == MOVE) && (t_load ? (t_load_val == '0) : (t_count == TW'(1)));
        up_d   = step && dir_d;
        down_d = step && !dir_d;
        open_d = (state_d == DOOR);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            open_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            up_q    <= up_d;
            down_q  <= down_d;
            open_q  <= open_d;
            busy_q  <= busy_d;
        end
    end

    assign up     = up_q;
    assign down   = down_q;
    assign open   = open_q;
    assign dir_up = dir_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench: a ten-floor datapath emulation plus a phase/elapsed-cycle model of the controller.
module tb_elevator_controller;

    localparam int MOVE_CYCLES = 4;
    localparam int DOOR_CYCLES = 8;
    localparam int NF          = 10;
    localparam int M_IDLE      = 0;
    localparam int M_DOOR      = 1;
    localparam int M_MOVE      = 2;
    localparam int M_SETTLE    = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic request_i, request_j_gt_i, request_j_lt_i, door_hold;
    logic up, down, open, dir_up, busy;

    logic [NF-1:0] req;
    int floor;
    int cyc;
    int checks = 0;
    int errors = 0;
    int up_cnt, down_cnt, open_cnt, n;
    int pulse_cyc[$];
    int open_floors[$];
    logic prev_open;

    int   m_mode = M_IDLE;
    int   m_elapsed = 0;
    logic m_dir = 1'b1;
    logic exp_up, exp_down, exp_open, exp_busy;

    elevator_controller #(
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .request_i      (request_i),
        .request_j_gt_i (request_j_gt_i),
        .request_j_lt_i (request_j_lt_i),
        .door_hold      (door_hold),
        .up             (up),
        .down           (down),
        .open           (open),
        .dir_up         (dir_up),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        request_i      = 1'b0;
        request_j_gt_i = 1'b0;
        request_j_lt_i = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (req[f]) begin
                if (f == floor)     request_i      = 1'b1;
                else if (f > floor) request_j_gt_i = 1'b1;
                else                request_j_lt_i = 1'b1;
            end
        end
    end

    // Model: which phase we are in and how many cycles of it have elapsed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= M_IDLE;
            m_elapsed <= 0;
            m_dir     <= 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_elapsed <= 0;
                    if (request_i) m_mode <= M_DOOR;
                    else if (request_j_gt_i) begin m_mode <= M_MOVE; m_dir <= 1'b1; end
                    else if (request_j_lt_i) begin m_mode <= M_MOVE; m_dir <= 1'b0; end
                end
                M_DOOR: begin
                    if (door_hold) m_elapsed <= 0;
                    else if (m_elapsed == DOOR_CYCLES - 1) m_mode <= M_SETTLE;
                    else m_elapsed <= m_elapsed + 1;
                end
                M_MOVE: begin
                    if (m_elapsed == MOVE_CYCLES - 1) m_mode <= M_SETTLE;
                    else m_elapsed <= m_elapsed + 1;
                end
                default: begin
                    m_elapsed <= 0;
                    if (request_i) m_mode <= M_DOOR;
                    else if (m_dir ? request_j_gt_i : request_j_lt_i) m_mode <= M_MOVE;
                    else if (m_dir ? request_j_lt_i : request_j_gt_i) begin
                        m_mode <= M_MOVE;
                        m_dir  <= ~m_dir;
                    end else m_mode <= M_IDLE;
                end
            endcase
        end
    end

    assign exp_up   = (m_mode == M_MOVE) && (m_elapsed == MOVE_CYCLES - 1) && m_dir;
    assign exp_down = (m_mode == M_MOVE) && (m_elapsed == MOVE_CYCLES - 1) && !m_dir;
    assign exp_open = (m_mode == M_DOOR);
    assign exp_busy = (m_mode != M_IDLE);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int f);
        req[f] = 1'b1;
    endtask

    // One cycle: compare DUT to model mid-cycle, then let the datapath react to the model's outputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        checkOutput("up", up, exp_up);
        checkOutput("down", down, exp_down);
        checkOutput("open", open, exp_open);
        checkOutput("dir_up", dir_up, m_dir);
        checkOutput("busy", busy, exp_busy);
        checkOutput("exclusive", int'((up & down) | (up & open) | (down & open)), 0);
        checkOutput("end_floor_pulse", int'((up && floor == NF - 1) || (down && floor == 0)), 0);
        if (exp_open && !prev_open) open_floors.push_back(floor);
        prev_open = exp_open;
        if (exp_up) begin
            up_cnt++;
            pulse_cyc.push_back(cyc);
            if (floor < NF - 1) floor++;
        end
        if (exp_down) begin
            down_cnt++;
            pulse_cyc.push_back(cyc);
            if (floor > 0) floor--;
        end
        if (exp_open) begin
            open_cnt++;
            req[floor] = 1'b0;
        end
    endtask

    task automatic clearCounts();
        up_cnt = 0;
        down_cnt = 0;
        open_cnt = 0;
        pulse_cyc.delete();
        open_floors.delete();
    endtask

    task automatic waitOpen(output int k);
        k = 0;
        while (!exp_open && k < 500) begin tick(); k++; end
        if (!exp_open) checkOutput("wait_open_timeout", 0, 1);
    endtask

    task automatic waitClose();
        int k = 0;
        while (exp_open && k < 500) begin tick(); k++; end
        if (exp_open) checkOutput("wait_close_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        int k = 0;
        while (exp_busy && k < 500) begin tick(); k++; end
        if (exp_busy) checkOutput("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        floor = 0;
        door_hold = 1'b0;
        cyc = 0;
        prev_open = 1'b0;
        clearCounts();
        repeat (3) tick();
        checkOutput("rst_up", up, 0);
        checkOutput("rst_open", open, 0);
        checkOutput("rst_dir_up", dir_up, 1);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Request at the current floor.
        clearCounts();
        applyStimulus(0);
        waitOpen(n);
        checkOutput("t1_open_latency", n, 1);
        waitIdle();
        checkOutput("t1_open_cycles", open_cnt, DOOR_CYCLES);
        checkOutput("t1_pulses", up_cnt + down_cnt, 0);
        checkOutput("t1_idle_busy", busy, 0);

        // Three floors up from 0.
        clearCounts();
        applyStimulus(3);
        waitOpen(n);
        checkOutput("t2_open_latency", n, 16);
        checkOutput("t2_floor", floor, 3);
        checkOutput("t2_up_pulses", up_cnt, 3);
        checkOutput("t2_dir_up", dir_up, 1);
        checkOutput("t2_pulse_count", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            checkOutput("t2_spacing_a", pulse_cyc[1] - pulse_cyc[0], 5);
            checkOutput("t2_spacing_b", pulse_cyc[2] - pulse_cyc[1], 5);
        end
        waitIdle();

        // Park at 5, then requests above and below.
        applyStimulus(5);
        waitOpen(n);
        waitIdle();
        checkOutput("t3_start_floor", floor, 5);
        clearCounts();
        applyStimulus(7);
        applyStimulus(2);
        waitOpen(n);
        checkOutput("t3_first_stop", floor, 7);
        checkOutput("t3_up_pulses", up_cnt, 2);
        waitClose();
        waitOpen(n);
        checkOutput("t3_second_stop", floor, 2);
        checkOutput("t3_down_pulses", down_cnt, 5);
        checkOutput("t3_dir_flipped", dir_up, 0);
        checkOutput("t3_stops", open_floors.size(), 2);
        waitIdle();

        // Door hold from door cycle 4 for 20 cycles.
        clearCounts();
        applyStimulus(2);
        waitOpen(n);
        repeat (4) tick();
        door_hold = 1'b1;
        repeat (20) tick();
        door_hold = 1'b0;
        waitIdle();
        checkOutput("t4_hold_open_cycles", open_cnt, 32);

        // Request at the current floor during the last open cycle re-opens after one SETTLE cycle.
        clearCounts();
        applyStimulus(2);
        waitOpen(n);
        repeat (DOOR_CYCLES - 1) tick();
        applyStimulus(2);
        tick();
        checkOutput("t4_settle_gap", open, 0);
        tick();
        checkOutput("t4_reopen", open, 1);
        waitIdle();
        checkOutput("t4_reopen_cycles", open_cnt, 2 * DOOR_CYCLES);
        checkOutput("t4_reopen_rises", open_floors.size(), 2);

        // Reset two cycles before the first pulse.
        clearCounts();
        applyStimulus(4);
        repeat (2) tick();
        rst_n = 1'b0;
        req = '0;
        repeat (3) tick();
        checkOutput("t5_rst_up", up, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_dir", dir_up, 1);
        rst_n = 1'b1;
        tick();
        checkOutput("t5_rel_up", up, 0);
        checkOutput("t5_rel_down", down, 0);
        checkOutput("t5_rel_open", open, 0);
        checkOutput("t5_rel_busy", busy, 0);
        checkOutput("t5_no_pulse", up_cnt + down_cnt, 0);
        checkOutput("t5_floor_kept", floor, 2);
        applyStimulus(4);
        waitOpen(n);
        checkOutput("t5_latency", n, 11);
        checkOutput("t5_floor", floor, 4);
        waitIdle();

        // Top floor with only a request below.
        applyStimulus(9);
        waitOpen(n);
        waitIdle();
        checkOutput("t6_top_floor", floor, 9);
        checkOutput("t6_dir_before", dir_up, 1);
        clearCounts();
        applyStimulus(6);
        tick();
        checkOutput("t6_dir_down", dir_up, 0);
        waitOpen(n);
        checkOutput("t6_floor", floor, 6);
        checkOutput("t6_up_pulses", up_cnt, 0);
        checkOutput("t6_down_pulses", down_cnt, 3);
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
